// File: rtl/iob_dma_sched_if.sv
// Bundle of requester-side and DMA-side signals for the DMA scheduler.
// The scheduler takes the slave view; the requesters and the DMA engine take the master view.
interface iob_dma_sched_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 32,
   parameter int SIZE_W = 32,
   parameter int IF_W   = 1
);
   logic [N_REQ-1:0]        req_valid_i;
   logic [N_REQ-1:0]        req_ready_o;
   logic [N_REQ-1:0]        req_dir_i;
   logic [N_REQ*ADDR_W-1:0] req_addr_i;
   logic [N_REQ*SIZE_W-1:0] req_size_i;
   logic [N_REQ*IF_W-1:0]   req_if_i;
   logic [N_REQ-1:0]        done_o;
   logic [N_REQ-1:0]        grant_o;
   logic                    busy_o;
   logic [ADDR_W-1:0]       dma_addr_o;
   logic [SIZE_W-1:0]       dma_size_o;
   logic                    dma_dir_o;
   logic [IF_W-1:0]         dma_if_o;
   logic                    dma_addr_wr_o;
   logic                    dma_size_wr_o;
   logic                    dma_ready_r_i;
   logic                    dma_ready_w_i;

   modport slave (
      input  req_valid_i, req_dir_i, req_addr_i, req_size_i, req_if_i,
      input  dma_ready_r_i, dma_ready_w_i,
      output req_ready_o, done_o, grant_o, busy_o,
      output dma_addr_o, dma_size_o, dma_dir_o, dma_if_o, dma_addr_wr_o, dma_size_wr_o
   );

   modport master (
      output req_valid_i, req_dir_i, req_addr_i, req_size_i, req_if_i,
      output dma_ready_r_i, dma_ready_w_i,
      input  req_ready_o, done_o, grant_o, busy_o,
      input  dma_addr_o, dma_size_o, dma_dir_o, dma_if_o, dma_addr_wr_o, dma_size_wr_o
   );
endinterface

// File: rtl/iob_dma_sched.sv
// Round-robin scheduler sharing one DMA engine between N_REQ descriptor requesters.
// Programs the engine's base/size registers, waits for start and completion, then pulses done.
module iob_dma_sched #(
   parameter int N_REQ    = 4,
   parameter int ADDR_W   = 32,
   parameter int SIZE_W   = 32,
   parameter int IF_W     = 1,
   parameter int START_TO = 16
) (
   input  logic           clk_i,
   input  logic           cke_i,
   input  logic           arst_n_i,
   iob_dma_sched_if.slave bus
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (START_TO > 1) ? $clog2(START_TO) : 1;

   typedef enum logic [2:0] {
      IDLE, GRANT, CFG_1, CFG_2, WAIT_START, WAIT_DONE, DONE
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  last_grant;
   logic [CNT_W-1:0]  start_cnt;

   logic [IDX_W-1:0]  cand;
   logic [IDX_W-1:0]  win_idx;
   logic              win_found;
   logic [N_REQ-1:0]  win_oh;
   logic [ADDR_W-1:0] sel_addr;
   logic [SIZE_W-1:0] sel_size;
   logic [IF_W-1:0]   sel_if;
   logic              sel_dir;
   logic              dma_flag;

   // Search starts just after the previous owner so every requester gets a turn.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      win_found = 1'b0;
      win_idx   = last_grant;
      cand      = last_grant;
      for (int k = 0; k < N_REQ; k++) begin
         // NOTE: blocking assignments here because cand is a running value within one evaluation.
         cand = (cand == IDX_W'(N_REQ - 1)) ? '0 : cand + IDX_W'(1);
         if (!win_found && bus.req_valid_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_size = '0;
      sel_if   = '0;
      sel_dir  = 1'b0;
      win_oh   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            sel_addr  = bus.req_addr_i[i*ADDR_W +: ADDR_W];
            sel_size  = bus.req_size_i[i*SIZE_W +: SIZE_W];
            sel_if    = bus.req_if_i[i*IF_W +: IF_W];
            sel_dir   = bus.req_dir_i[i];
            win_oh[i] = 1'b1;
         end
      end
   end

   // Stream-in transfers finish on the write side, stream-out on the read side.
   assign dma_flag = bus.dma_dir_o ? bus.dma_ready_w_i : bus.dma_ready_r_i;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
         state             <= IDLE;
         last_grant        <= IDX_W'(N_REQ - 1);
         start_cnt         <= '0;
         bus.req_ready_o   <= '0;
         bus.done_o        <= '0;
         bus.grant_o       <= '0;
         bus.busy_o        <= 1'b0;
         bus.dma_addr_o    <= '0;
         bus.dma_size_o    <= '0;
         bus.dma_dir_o     <= 1'b0;
         bus.dma_if_o      <= '0;
         bus.dma_addr_wr_o <= 1'b0;
         bus.dma_size_wr_o <= 1'b0;
      end else if (cke_i) begin
         bus.req_ready_o   <= '0;
         bus.done_o        <= '0;
         bus.dma_addr_wr_o <= 1'b0;
         bus.dma_size_wr_o <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  state           <= GRANT;
                  last_grant      <= win_idx;
                  bus.req_ready_o <= win_oh;
                  bus.grant_o     <= win_oh;
                  bus.busy_o      <= 1'b1;
                  bus.dma_addr_o  <= sel_addr;
                  bus.dma_size_o  <= sel_size;
                  bus.dma_dir_o   <= sel_dir;
                  bus.dma_if_o    <= sel_if;
               end
            end
            GRANT: begin
               if (bus.dma_size_o == '0) begin
                  state      <= DONE;
                  bus.done_o <= bus.grant_o;
               end else begin
                  state             <= CFG_1;
                  bus.dma_size_wr_o <= bus.dma_dir_o;
                  bus.dma_addr_wr_o <= !bus.dma_dir_o;
               end
            end
            CFG_1: begin
               state             <= CFG_2;
               bus.dma_addr_wr_o <= bus.dma_dir_o;
               bus.dma_size_wr_o <= !bus.dma_dir_o;
            end
            CFG_2: begin
               state     <= WAIT_START;
               start_cnt <= '0;
            end
            WAIT_START: begin
               // A flag that never drops means the engine started and finished unseen.
               if (!dma_flag || start_cnt == CNT_W'(START_TO - 1)) begin
                  state     <= WAIT_DONE;
                  start_cnt <= '0;
               end else begin
                  start_cnt <= start_cnt + CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (dma_flag) begin
                  state      <= DONE;
                  bus.done_o <= bus.grant_o;
               end
            end
            DONE: begin
               state       <= IDLE;
               bus.grant_o <= '0;
               bus.busy_o  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/iob_dma_sched.md
IOB_DMA_SCHED -- requirements
Module: iob_dma_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters sharing one DMA engine (2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 32, width of transfer base address.
REQ-003 The block SHALL have parameter SIZE_W, default 32, width of transfer size in words.
REQ-004 The block SHALL have parameter IF_W, default 1, width of stream interface number.
REQ-005 The block SHALL have parameter START_TO, default 16, cycles to wait for DMA start acknowledge.
REQ-006 The block SHALL use one clock and an asynchronous active-low reset: clk_i  in  1  clock; cke_i  in  1  clock enable; arst_n_i  in  1  asynchronous active-low reset.
REQ-007 req_valid_i  in  N_REQ  per-requester descriptor valid.
REQ-008 req_ready_o  out  N_REQ  per-requester descriptor accept.
REQ-009 req_dir_i  in  N_REQ  direction per requester; 1 = stream-in to memory, 0 = memory to stream-out.
REQ-010 req_addr_i  in  N_REQ*ADDR_W  packed base addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-011 req_size_i  in  N_REQ*SIZE_W  packed sizes, same packing.
REQ-012 req_if_i  in  N_REQ*IF_W  packed interface numbers, same packing.
REQ-013 done_o  out  N_REQ  one-cycle completion pulse per requester.
REQ-014 grant_o  out  N_REQ  one-hot owner of DMA, zero when idle.
REQ-015 busy_o  out  1  high in every state except IDLE.
REQ-016 dma_addr_o  out  ADDR_W; dma_size_o  out  SIZE_W; dma_dir_o  out  1; dma_if_o  out  IF_W: registered DMA configuration.
REQ-017 dma_addr_wr_o  out  1; dma_size_wr_o  out  1: one-cycle register-write strobes to DMA BASE_ADDR / TRANSFER_SIZE.
REQ-018 dma_ready_r_i  in  1; dma_ready_w_i  in  1: DMA read-side / write-side idle flags.

Function
REQ-019 All state SHALL advance only when cke_i=1.
REQ-020 FSM states SHALL be IDLE, GRANT, CFG_1, CFG_2, WAIT_START, WAIT_DONE, DONE.
REQ-021 IDLE: if any req_valid_i set -> GRANT; else stay.
REQ-022 Arbitration SHALL be round-robin: search from (last_grant+1) mod N_REQ upward, first valid wins; last_grant updates on acceptance.
REQ-023 GRANT (1 cycle): req_ready_o[winner]=1, descriptor latched into dma_*_o, grant_o set; size=0 -> DONE, else -> CFG_1.
REQ-024 Write order SHALL depend on direction: dir=1 CFG_1 pulses dma_size_wr_o, CFG_2 pulses dma_addr_wr_o; dir=0 CFG_1 pulses dma_addr_wr_o, CFG_2 pulses dma_size_wr_o.
REQ-025 Selected flag SHALL be dma_ready_w_i for dir=1, dma_ready_r_i for dir=0.
REQ-026 WAIT_START: selected flag low -> WAIT_DONE; else a counter reaching START_TO-1 -> WAIT_DONE (engine assumed started).
REQ-027 WAIT_DONE: selected flag high -> DONE; no timeout.
REQ-028 DONE (1 cycle): done_o[owner]=1, grant_o cleared next cycle, -> IDLE.
REQ-029 A requester SHALL hold valid and descriptor stable until req_ready_o; deassertion before grant withdraws the request without error.
REQ-030 dma_*_o SHALL hold their value after DONE until the next GRANT.
REQ-031 Only one transfer SHALL be outstanding; new requests during a transfer wait.
REQ-032 done_o, req_ready_o, strobes SHALL never be high for more than one consecutive cycle.

Reset
REQ-033 arst_n_i=0 SHALL immediately force state IDLE, last_grant=N_REQ-1 (requester 0 wins first), all outputs 0, start counter 0, including mid-transfer; no done_o is issued for the aborted transfer.

Verification
REQ-034 Single dir=0 request from req 2, addr 0x100, size 8: addr strobe then size strobe, dma_ready_r_i low 3 cycles later, high after 20 -> done_o[2] one pulse, busy_o low next cycle.
REQ-035 Requests 0,1,3 simultaneously valid, repeated: grant order 0,1,3,0,1,3; no requester starved.
REQ-036 dir=1 request size 4: dma_size_wr_o precedes dma_addr_wr_o by exactly 1 cycle; completion on dma_ready_w_i only, dma_ready_r_i toggling ignored.
REQ-037 Size 0 request: no strobes, done_o pulses 2 cycles after acceptance.
REQ-038 dma_ready_r_i held high throughout: WAIT_START exits after START_TO=16 cycles, done_o then fires on the still-high flag.
REQ-039 arst_n_i asserted in WAIT_DONE: all outputs 0 same cycle, no done_o; after release requester 0 wins first.
